// File: rtl/memo_ram_pkg.sv
// Shared definitions for the unified instruction/data memory.
package memo_ram_pkg;

  localparam int MEM_DATA_W = 16;
  localparam int MEM_ADDR_W = 6;
  localparam int MEM_DEPTH  = 2 ** MEM_ADDR_W;

  typedef logic [MEM_DATA_W-1:0] mem_word_t;
  typedef logic [MEM_ADDR_W-1:0] mem_addr_t;

endpackage

// File: rtl/memo_ram_array_1p.sv
// Plain storage array: synchronous write, asynchronous read, all-zero
// power-up contents.
module ram_array_1p #(
  parameter int    DATA_W    = 16,
  parameter int    ADDR_W    = 6,
  parameter string INIT_FILE = ""
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // Power-up contents: zero-fill.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  // Write port: the word lands on the edge that samples wr_en.
  always @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port is combinational; the caller registers both address and data,
  // which is the shape block-RAM inference with output register expects.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/memo_ram.sv
// Single-port 64x16 RAM with registered address and registered output.
// Read latency is two edges from address presentation to valid q; a write
// at edge N is visible to a read of the same word at edge N+1.
module memo_ram
  import memo_ram_pkg::*;
#(
  parameter int    DATA_W    = MEM_DATA_W,
  parameter int    ADDR_W    = MEM_ADDR_W,
  parameter string INIT_FILE = ""
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic [DATA_W-1:0] q
);

  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] q_p1;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;

  // Writes are suppressed for as long as reset is held; contents survive.
  assign wr_en = wren & resetn;

  // Write uses the live port address, read uses the registered one.
  ram_array_1p #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (address),
    .wr_data (data),
    .rd_addr (addr_p0),
    .rd_data (rd_data)
  );

  // Stage p0 captures the address; stage p1 captures the word it selected.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_p0 <= '0;
      q_p1    <= '0;
    end else begin
      addr_p0 <= address;
      q_p1    <= rd_data;
    end
  end

  assign q = q_p1;

endmodule

// File: tb/tb_memo_ram.sv
// Bench for memo_ram: a reference memory model predicts every q value at the
// moment the address is driven; predictions are queued and compared as the
// DUT produces them two edges later.
module tb_memo_ram;
  import memo_ram_pkg::*;

  logic      clock   = 1'b0;
  logic      resetn  = 1'b1;
  mem_addr_t address = '0;
  mem_word_t data    = '0;
  logic      wren    = 1'b0;
  mem_word_t q;

  memo_ram #(
    .DATA_W    (MEM_DATA_W),
    .ADDR_W    (MEM_ADDR_W),
    .INIT_FILE ("")
  ) dut (
    .clock   (clock),
    .resetn  (resetn),
    .address (address),
    .data    (data),
    .wren    (wren),
    .q       (q)
  );

  always #50 clock = ~clock;

  mem_word_t model [MEM_DEPTH];
  mem_word_t sb [$];
  int        n_tests = 0;
  int        n_fail  = 0;
  string     phase   = "init";

  task automatic chk_eq(input string tag, input mem_word_t got, input mem_word_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: q=%h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: called at a falling edge, drives inputs, predicts the q
  // that will appear one edge after the next, then checks the q produced by
  // the previous cycle's address. Returns at the following falling edge.
  task automatic cyc(input mem_addr_t a, input mem_word_t d, input logic we);
    mem_word_t exp;
    address = a;
    data    = d;
    wren    = we;
    if (we) model[a] = d;
    sb.push_back(model[a]);
    @(posedge clock);
    #1;
    if (sb.size() >= 2) begin
      exp = sb.pop_front();
      chk_eq(phase, q, exp);
    end
    @(negedge clock);
  endtask

  // Reset pulse asserted between edges; a write attempted during reset must
  // not land. After release, addr_reg is 0, so the first edge returns word 0.
  task automatic pulse_reset(input string tag);
    @(posedge clock);
    #20;
    resetn = 1'b0;
    #1;
    chk_eq({tag, "_immediate"}, q, '0);
    address = 6'd7;
    data    = 16'hDEAD;
    wren    = 1'b1;
    @(posedge clock);
    #1;
    chk_eq({tag, "_held"}, q, '0);
    @(negedge clock);
    resetn  = 1'b1;
    wren    = 1'b0;
    address = '0;
    data    = '0;
    sb.delete();
    sb.push_back(model[0]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < MEM_DEPTH; i++) model[i] = '0;

    pulse_reset("reset_start");

    // 1: read word 1; first edge shows word 0 via reset addr_reg, then 0.
    phase = "t1_read_zero";
    cyc(6'd1, '0, 1'b0);
    cyc(6'd1, '0, 1'b0);

    // 2: write 42 to word 1 then keep reading it.
    phase = "t2_rdw";
    cyc(6'd1, 16'd42, 1'b1);
    cyc(6'd1, '0, 1'b0);
    cyc(6'd1, '0, 1'b0);
    cyc(6'd1, '0, 1'b0);

    // 3: move to word 2; old word shows for one more edge.
    phase = "t3_addr_change";
    cyc(6'd2, '0, 1'b0);
    cyc(6'd2, '0, 1'b0);
    cyc(6'd2, '0, 1'b0);

    // 4: write 1 to word 0 and hold.
    phase = "t4_word0";
    cyc(6'd0, 16'd1, 1'b1);
    cyc(6'd0, '0, 1'b0);
    cyc(6'd0, '0, 1'b0);

    // 5: back-to-back writes, then back-to-back reads.
    phase = "t5_burst";
    cyc(6'd5,  16'hAAAA, 1'b1);
    cyc(6'd10, 16'h1234, 1'b1);
    cyc(6'd20, 16'hFFFF, 1'b1);
    cyc(6'd5,  '0, 1'b0);
    cyc(6'd10, '0, 1'b0);
    cyc(6'd20, '0, 1'b0);
    cyc(6'd20, '0, 1'b0);

    // 6: reset mid-read; contents retained, blocked write to word 7.
    phase = "t6_reset_mid";
    cyc(6'd10, '0, 1'b0);
    pulse_reset("reset_mid");
    cyc(6'd20, '0, 1'b0);
    cyc(6'd20, '0, 1'b0);
    cyc(6'd7,  '0, 1'b0);
    cyc(6'd7,  '0, 1'b0);

    // Address change and write in the same cycle writes the new address.
    phase = "t7_write_new_addr";
    cyc(6'd30, '0, 1'b0);
    cyc(6'd31, 16'h5A5A, 1'b1);
    cyc(6'd30, '0, 1'b0);
    cyc(6'd31, '0, 1'b0);
    cyc(6'd0,  '0, 1'b0);

    // Mixed random traffic against the model.
    phase = "t8_random";
    for (int i = 0; i < 80; i++) begin
      cyc(mem_addr_t'($urandom_range(0, MEM_DEPTH - 1)),
          mem_word_t'($urandom),
          ($urandom_range(0, 2) == 0));
    end
    cyc(6'd0, '0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
